// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift/add multiplier controller.
// One operand pair is accepted per operation; the multiplicand doubles every
// RUN step while the multiplier LSB decides whether it is accumulated. The
// latency is fixed at WIDTH RUN cycles plus one DONE cycle, whatever the
// operand values.
//
// Handshake: start is a request that is taken only while the controller is
// IDLE (busy=0). The rising edge that sees start=1 in IDLE captures a and b;
// start, a and b are ignored at every other edge, and nothing is queued.
// busy is high from the cycle after acceptance through the DONE cycle. done is
// a single-cycle pulse during which product carries the new result. product
// then holds that value until the next operation completes.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    mcand_next;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_next;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_next;
  logic [PW-1:0]    product_next;
  logic [PW-1:0]    sum;
  logic             last_step;
  logic             busy_next;
  logic             done_next;

  // The enum encoding is exported so that checkers can follow the FSM.
  assign state_dbg = state;

  // FSM state, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      acc     <= acc_next;
      step    <= step_next;
      product <= product_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Next-state and datapath update. The accumulator add is 2*WIDTH bits
  // wide, so it cannot overflow. On the last step the product takes the
  // accumulator value that includes that step's add.
  always_comb begin
    state_next   = state;
    mcand_next   = mcand;
    mplier_next  = mplier;
    acc_next     = acc;
    step_next    = step;
    product_next = product;
    sum          = mplier[0] ? (acc + mcand) : acc;
    last_step    = (step == SW'(WIDTH - 1));

    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          acc_next    = '0;
          step_next   = '0;
        end
      end
      RUN: begin
        acc_next    = sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        step_next   = step + SW'(1);
        if (last_step) begin
          product_next = sum;
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // busy and done are registered from the next state. start therefore
    // has no combinational path to any output.
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl (WIDTH=4): vector table, hand-written
// back-to-back and reset-abort sequences, random operands, and a product
// scoreboard fed at stimulus time.
module tb_shift_add_mult_ctrl;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic [1:0]    state_dbg;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            done_seen = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_product = '0;
  logic [PW-1:0] mon_exp;

  typedef struct {
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic [PW-1:0] ve;
    bit            poke;
  } vec_t;

  vec_t vecs[8];

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .state_dbg (state_dbg)
  );

  // clock / reset-independent clock generator
  always #5 clk = ~clk;

  // Upper bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected product
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", product, mon_exp);
        last_product = mon_exp;
      end
    end
  end

  // Drive one operation from a negedge with the DUT idle and return one
  // negedge after the done pulse (DUT idle again). With poke set, start is
  // also pulsed during RUN and during DONE with other operands.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [PW-1:0] ve, input bit poke);
    int got;
    int dones_before;
    logic [PW-1:0] prev;
    prev = last_product;
    dones_before = done_seen;
    a = va;
    b = vb;
    start = 1'b1;
    exp_q.push_back(ve);
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
        check("product_hold", product, prev);
      end
      if (poke && k == 2) begin
        start = 1'b1;
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
      end
      if (poke && k == 3) start = 1'b0;
      check("busy_run", busy, 1);
      if (done === 1'b1) begin
        got = k;
        break;
      end
    end
    check("latency", got, 5);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_idle", busy, 0);
    check("done_pulse", done, 0);
    check("done_count", done_seen - dones_before, 1);
  endtask

  initial begin
    int ra;
    int rb;
    int times[$];

    vecs[0] = '{4'd7,  4'd2,  8'd14,  1'b0};
    vecs[1] = '{4'd7,  4'd8,  8'd56,  1'b0};
    vecs[2] = '{4'd15, 4'd15, 8'd225, 1'b1};
    vecs[3] = '{4'd0,  4'd9,  8'd0,   1'b0};
    vecs[4] = '{4'd9,  4'd0,  8'd0,   1'b1};
    vecs[5] = '{4'd1,  4'd1,  8'd1,   1'b0};
    vecs[6] = '{4'd15, 4'd1,  8'd15,  1'b0};
    vecs[7] = '{4'd1,  4'd15, 8'd15,  1'b1};

    // Reset
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_product", product, 0);
    end

    // Vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ve, vecs[i].poke);
    end

    // Start held high: back-to-back operations every 6 cycles
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    repeat (3) exp_q.push_back(8'd15);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2)  begin a = 4'd12; b = 4'd13; end
      if (c == 4)  begin a = 4'd3;  b = 4'd5;  end
      if (c == 8)  begin a = 4'd1;  b = 4'd2;  end
      if (c == 10) begin a = 4'd3;  b = 4'd5;  end
      if (c == 17) start = 1'b0;
      if (done === 1'b1) times.push_back(c);
      check("b2b_busy", busy, (c == 6 || c == 12 || c >= 18) ? 0 : 1);
    end
    check("b2b_count", times.size(), 3);
    for (int i = 0; i < times.size() && i < 3; i++) begin
      check("b2b_time", times[i], 5 + 6 * i);
    end

    // Reset two cycles into an operation
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_hold_done", done, 0);
      check("abort_hold_busy", busy, 0);
    end
    rst_n = 1'b1;
    last_product = '0;
    @(negedge clk);
    check("post_abort_busy", busy, 0);
    check("post_abort_product", product, 0);
    run_op(4'd6, 4'd7, 8'd42, 1'b0);

    // Random operands
    for (int i = 0; i < 200; i++) begin
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      run_op(W'(ra), W'(rb), PW'(ra * rb), (i % 4) == 0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
